// File: rtl/multi_tick_divider.sv
// multi_tick_divider
//   NUM_CH independent, run-time programmable tick generators. Channel 0 also
//   serves as the ramp timebase: every RAMP_PERIOD ch0 ticks, each channel
//   with ramp_en set has its divisor reduced by RAMP_STEP, saturating at
//   RAMP_MIN. A divisor already below RAMP_MIN is left alone by the ramp.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   en_i         count enable; low freezes counters and forces ticks to 0
//   cfg_wr_i     single-cycle divisor write strobe
//   cfg_ch_i     channel written by cfg_wr_i; also selects cur_div_o
//   cfg_div_i    divisor for the write (0 is stored as 1)
//   ramp_en_i    per-channel ramp enable
//   ramp_clr_i   clears the ramp event counter (wins over a ch0 tick)
//   tick_o       registered single-cycle strobe per channel
//   cur_div_o    divisor of channel cfg_ch_i, 0 when cfg_ch_i >= NUM_CH
//   ramp_done_o  registered; ramp_en_i[i] && divisor[i] == RAMP_MIN
module multi_tick_divider #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CH_IDX_W    = 2,
    parameter int unsigned CNT_W       = 27,
    parameter int unsigned RST_DIV     = 100000000,
    parameter int unsigned RAMP_PERIOD = 3,
    parameter int unsigned RAMP_STEP   = 3750000,
    parameter int unsigned RAMP_MIN    = 8333333
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                cfg_wr_i,
    input  logic [CH_IDX_W-1:0] cfg_ch_i,
    input  logic [CNT_W-1:0]    cfg_div_i,
    input  logic [NUM_CH-1:0]   ramp_en_i,
    input  logic                ramp_clr_i,
    output logic [NUM_CH-1:0]   tick_o,
    output logic [CNT_W-1:0]    cur_div_o,
    output logic [NUM_CH-1:0]   ramp_done_o
);

    localparam int unsigned      RC_W       = (RAMP_PERIOD > 1) ? $clog2(RAMP_PERIOD) : 1;
    localparam logic [CNT_W-1:0] DIV_RST    = CNT_W'(RST_DIV);
    localparam logic [CNT_W:0]   STEP_X     = (CNT_W+1)'(RAMP_STEP);
    localparam logic [CNT_W:0]   MIN_X      = (CNT_W+1)'(RAMP_MIN);
    localparam logic [CNT_W:0]   MIN_STEP_X = MIN_X + STEP_X;
    localparam logic [RC_W-1:0]  RC_LAST    = RC_W'(RAMP_PERIOD - 1);

    logic [CNT_W-1:0]  div_q [NUM_CH];
    logic [CNT_W-1:0]  div_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic [NUM_CH-1:0] wr_hit;
    logic              ramp_ev;
    logic [CNT_W:0]    inc;
    logic [CNT_W:0]    dx;

    // Decode the config write; out-of-range channels hit nothing.
    always_comb begin
        wr_hit = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg_wr_i && (32'(cfg_ch_i) == i)) begin
                wr_hit[i] = 1'b1;
            end
        end
    end

    always_comb begin
        tick_d  = '0;
        done_d  = '0;
        rc_d    = rc_q;
        ramp_ev = 1'b0;
        inc     = '0;
        dx      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            div_d[i] = div_q[i];
            cnt_d[i] = cnt_q[i];
        end

        // Counters. The >= compare lets a channel recover at once when its
        // divisor has been ramped below the running count.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            inc = {1'b0, cnt_q[i]} + 1'b1;
            if (wr_hit[i]) begin
                cnt_d[i] = '0;
            end else if (en_i) begin
                if (inc >= {1'b0, div_q[i]}) begin
                    tick_d[i] = 1'b1;
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = inc[CNT_W-1:0];
                end
            end
        end

        // Ramp event counter advances on the ch0 tick being registered this edge.
        if (ramp_clr_i) begin
            rc_d = '0;
        end else if (tick_d[0]) begin
            if (rc_q == RC_LAST) begin
                rc_d    = '0;
                ramp_ev = 1'b1;
            end else begin
                rc_d = rc_q + 1'b1;
            end
        end

        // Divisors: a config write overrides a coincident ramp decrement.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            dx = {1'b0, div_q[i]};
            if (wr_hit[i]) begin
                div_d[i] = (cfg_div_i == '0) ? CNT_W'(1) : cfg_div_i;
            end else if (ramp_ev && ramp_en_i[i]) begin
                if (dx >= MIN_STEP_X) begin
                    div_d[i] = div_q[i] - STEP_X[CNT_W-1:0];
                end else if (dx >= MIN_X) begin
                    div_d[i] = MIN_X[CNT_W-1:0];
                end
            end
            done_d[i] = ramp_en_i[i] && (dx == MIN_X);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DIV_RST;
                cnt_q[i] <= '0;
            end
            tick_q <= '0;
            done_q <= '0;
            rc_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            tick_q <= tick_d;
            done_q <= done_d;
            rc_q   <= rc_d;
        end
    end

    always_comb begin
        cur_div_o = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(cfg_ch_i) == i) begin
                cur_div_o = div_q[i];
            end
        end
    end

    assign tick_o      = tick_q;
    assign ramp_done_o = done_q;

endmodule
